usb_rcu: RTL
============

USB_RCU -- requirements
Module: usb_rcu

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port d_edge, input, 1, one-cycle pulse on any bus transition (from edge detector).
REQ-004 SHALL have port eop, input, 1, end-of-packet level (D+ and D- both low, from eop detector).
REQ-005 SHALL have port shift_enable, input, 1, one-cycle pulse at each bit sample point (from timer).
REQ-006 SHALL have port byte_received, input, 1, one-cycle pulse when the 8th bit of a byte is shifted in.
REQ-007 SHALL have port rcv_data, input, 8, current contents of the shift register, valid when byte_received is seen.
REQ-008 SHALL have port rcving, output, 1, high while a packet is in progress.
REQ-009 SHALL have port w_enable, output, 1, one-cycle FIFO write strobe for rcv_data.
REQ-010 SHALL have port r_error, output, 1, sticky packet-error flag.

Function
REQ-011 SHALL implement the states IDLE, SYNC_RCV, SYNC_CHK, BYTE_RCV, STORE, EOP_WAIT, ERR_WAIT, ERR_EOP, ERR_IDLE.
REQ-012 SHALL move IDLE->SYNC_RCV on d_edge and clear r_error on that edge.
REQ-013 SHALL move SYNC_RCV->SYNC_CHK on byte_received; eop && shift_enable in SYNC_RCV SHALL go to ERR_EOP.
REQ-014 SHALL spend exactly one cycle in SYNC_CHK: rcv_data == 8'h80 -> BYTE_RCV, else -> ERR_WAIT.
REQ-015 SHALL keep a 3-bit bit counter: cleared on entering BYTE_RCV, +1 per shift_enable in BYTE_RCV, and wrapping 7->0.
REQ-016 SHALL, in BYTE_RCV, go to STORE on byte_received, which has priority over eop.
REQ-017 SHALL, in BYTE_RCV with eop && shift_enable, go to EOP_WAIT if the bit counter is 0 and to ERR_EOP otherwise (truncated byte).
REQ-018 SHALL spend one cycle in STORE with w_enable=1, then return to BYTE_RCV.
REQ-019 SHALL move EOP_WAIT->IDLE on d_edge.
REQ-020 SHALL move ERR_WAIT->ERR_EOP on eop && shift_enable.
REQ-021 SHALL move ERR_EOP->ERR_IDLE on d_edge.
REQ-022 SHALL move ERR_IDLE->SYNC_RCV on d_edge and clear r_error then.
REQ-023 SHALL decode rcving as 1 in SYNC_RCV, SYNC_CHK, BYTE_RCV, STORE, EOP_WAIT, ERR_WAIT and ERR_EOP, and 0 in IDLE and ERR_IDLE.
REQ-024 SHALL decode w_enable as 1 only in STORE (Moore output, so it asserts in the cycle after the byte_received pulse).
REQ-025 SHALL register r_error: set on any entry to ERR_WAIT or ERR_EOP, held through ERR_IDLE and any subsequent IDLE, cleared only per REQ-012/REQ-022.
REQ-026 SHALL ignore d_edge in every state not listed above.
REQ-027 SHALL ignore eop when shift_enable is low, because eop is sampled only at bit points.
REQ-028 SHALL give byte_received priority when it coincides with eop && shift_enable in SYNC_RCV.

Reset
REQ-029 SHALL on n_rst low asynchronously force state=IDLE, bit counter=0, r_error=0, rcving=0, w_enable=0.
REQ-030 SHALL abandon any in-progress packet on reset and write nothing further to the FIFO.

Structure
REQ-031 SHALL place the state enum (4-bit encoding) and the SYNC_BYTE=8'h80 constant in shared package usb_rx_pkg.
REQ-032 SHALL implement the bit counter as one sub-module, rcu_bit_counter (clear, count_enable, 3-bit count, same clk/n_rst).
REQ-033 SHALL be otherwise flat, with one state register block and one next-state/output combinational block.

Verification
REQ-034 Good packet: d_edge, sync 8'h80, two data bytes 8'hA5 and 8'h3C, eop at counter 0, then d_edge -> exactly two w_enable pulses, r_error=0, rcving returns to 0.
REQ-035 Bad sync: first byte 8'h81 -> no w_enable, r_error=1 from SYNC_CHK+1 onward; after eop and d_edge the state is ERR_IDLE with rcving=0.
REQ-036 Truncated byte: valid sync, 5 shift_enable pulses, then eop && shift_enable -> r_error=1, no w_enable for the partial byte.
REQ-037 Error recovery: from ERR_IDLE, d_edge followed by a good packet -> r_error clears at the d_edge and data bytes are written.
REQ-038 Async reset mid-packet: assert n_rst between bits 3 and 4 of a data byte -> outputs 0 immediately, and the next d_edge starts SYNC_RCV.
REQ-039 Coincidence: byte_received and eop && shift_enable in the same cycle in BYTE_RCV -> STORE is taken and w_enable pulses once.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: RCU state encoding and the sync pattern.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SYNC_RCV = 4'd1,
    SYNC_CHK = 4'd2,
    BYTE_RCV = 4'd3,
    STORE    = 4'd4,
    EOP_WAIT = 4'd5,
    ERR_WAIT = 4'd6,
    ERR_EOP  = 4'd7,
    ERR_IDLE = 4'd8
  } rcu_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // A packet is in progress everywhere except the two resting states.
  function automatic logic is_rcving(input rcu_state_e s);
    return !((s == IDLE) || (s == ERR_IDLE));
  endfunction

endpackage

// File: rtl/usb_rcu_bit_counter.sv
// 3-bit bit-position counter for the RCU; wraps 7->0, clear wins over count.
module rcu_bit_counter
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       count_enable,
  output logic [2:0] count
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 3'd0;
    end else if (count_enable) begin
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/usb_rcu.sv
// USB receiver control unit: frames sync/data bytes between edges and EOP, strobes FIFO writes.
// States: IDLE bus idle | SYNC_RCV shifting sync | SYNC_CHK compare sync | BYTE_RCV shifting data
//   STORE write byte | EOP_WAIT good end, await edge | ERR_WAIT bad packet, await eop
//   ERR_EOP error end, await edge | ERR_IDLE idle after error, r_error held
module usb_rcu
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  rcu_state_e state_q, state_d;
  logic       r_error_q, r_error_d;
  logic       rcving_q, rcving_d;
  logic       w_enable_q, w_enable_d;
  logic       cnt_clear;
  logic       cnt_en;
  logic [2:0] bit_cnt;
  logic       eop_bit;

  assign eop_bit = eop && shift_enable;

  rcu_bit_counter u_bit_counter (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .count        (bit_cnt)
  );

  always_comb begin
    state_d   = state_q;
    r_error_d = r_error_q;
    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d   = SYNC_RCV;
          r_error_d = 1'b0;
        end
      end
      SYNC_RCV: begin
        if (byte_received) begin
          state_d = SYNC_CHK;
        end else if (eop_bit) begin
          state_d = ERR_EOP;
        end
      end
      SYNC_CHK: state_d = (rcv_data == SYNC_BYTE) ? BYTE_RCV : ERR_WAIT;
      BYTE_RCV: begin
        if (byte_received) begin
          state_d = STORE;
        end else if (eop_bit) begin
          // EOP is only legal on a byte boundary; anything else is a truncated byte.
          state_d = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_EOP;
        end
      end
      STORE:    state_d = BYTE_RCV;
      EOP_WAIT: if (d_edge) state_d = IDLE;
      ERR_WAIT: if (eop_bit) state_d = ERR_EOP;
      ERR_EOP:  if (d_edge) state_d = ERR_IDLE;
      ERR_IDLE: begin
        if (d_edge) begin
          state_d   = SYNC_RCV;
          r_error_d = 1'b0;
        end
      end
      default:  state_d = IDLE;
    endcase

    if ((state_d == ERR_WAIT) || (state_d == ERR_EOP)) begin
      r_error_d = 1'b1;
    end

    // Outputs are decoded from the next state so the registered copies track state_q exactly.
    rcving_d   = is_rcving(state_d);
    w_enable_d = (state_d == STORE);
    cnt_clear  = (state_d == BYTE_RCV) && (state_q != BYTE_RCV);
    cnt_en     = (state_q == BYTE_RCV) && shift_enable;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      r_error_q  <= 1'b0;
      rcving_q   <= 1'b0;
      w_enable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_error_q  <= r_error_d;
      rcving_q   <= rcving_d;
      w_enable_q <= w_enable_d;
    end
  end

  assign rcving   = rcving_q;
  assign w_enable = w_enable_q;
  assign r_error  = r_error_q;

endmodule
